// File: rtl/ripple_pkg.sv
// Shared types and constants for ripple counter capture logic.
package ripple_pkg;

    typedef enum logic {
        STABLE,
        SETTLING
    } state_t;

    localparam int GLITCH_CNT_W = 8;
    localparam logic [GLITCH_CNT_W-1:0] GLITCH_MAX = 8'd255;
    localparam int DEFAULT_N = 4;

endpackage

// File: rtl/ripple_count_capture_bus_sync2.sv
// Two-flop bus sampler with asynchronous active-high reset.
module bus_sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/ripple_count_capture.sv
// Filters ripple-counter transients, publishes settled values with deltas,
// and accumulates deltas into a wide running total.
module ripple_count_capture
    import ripple_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int SETTLE = 2,
    parameter int ACC_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            q_in,
    input  logic                    clear,
    output logic [N-1:0]            stable_q,
    output logic                    stable_valid,
    output logic [N-1:0]            delta,
    output logic                    wrap,
    output logic [ACC_W-1:0]        total,
    output logic                    acc_ovf,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    logic [N-1:0]   q_s2;
    state_t         state, state_nx;
    logic [N-1:0]   cand, cand_nx;
    logic [3:0]     run_cnt, run_nx;
    logic           accept, glitch;
    logic [N-1:0]   delta_nx;
    logic [ACC_W:0] sum;

    bus_sync2 #(.W(N)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (q_in),
        .q     (q_s2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= STABLE;
            cand    <= '0;
            run_cnt <= '0;
        end else begin
            state   <= state_nx;
            cand    <= cand_nx;
            run_cnt <= run_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        run_nx   = run_cnt;
        accept   = 1'b0;
        glitch   = 1'b0;
        case (state)
            STABLE: begin
                if (q_s2 != stable_q) begin
                    state_nx = SETTLING;
                    cand_nx  = q_s2;
                    run_nx   = 4'd1;
                end
            end
            SETTLING: begin
                if (q_s2 == cand) begin
                    run_nx = run_cnt + 4'd1;
                    if (run_nx == SETTLE_C) begin
                        accept   = 1'b1;
                        state_nx = STABLE;
                    end
                end else if (q_s2 == stable_q) begin
                    glitch   = 1'b1;
                    state_nx = STABLE;
                end else begin
                    glitch  = 1'b1;
                    cand_nx = q_s2;
                    run_nx  = 4'd1;
                end
            end
            default: state_nx = STABLE;
        endcase
    end

    // Modulo-2^N difference recovers counts missed while the bus was moving too fast.
    assign delta_nx = cand - stable_q;
    assign sum      = {1'b0, total} + {{(ACC_W + 1 - N){1'b0}}, delta_nx};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q     <= '0;
            stable_valid <= 1'b0;
            delta        <= '0;
            wrap         <= 1'b0;
            total        <= '0;
            acc_ovf      <= 1'b0;
            glitch_cnt   <= '0;
        end else begin
            stable_valid <= accept;
            wrap         <= accept && (cand < stable_q);
            if (accept) begin
                stable_q <= cand;
                delta    <= delta_nx;
            end
            // clear wins over both accumulation and glitch counting
            if (clear) begin
                total      <= '0;
                acc_ovf    <= 1'b0;
                glitch_cnt <= '0;
            end else begin
                if (accept) begin
                    total   <= sum[ACC_W-1:0];
                    acc_ovf <= acc_ovf | sum[ACC_W];
                end
                if (glitch && glitch_cnt != GLITCH_MAX)
                    glitch_cnt <= glitch_cnt + 8'd1;
            end
        end
    end

endmodule
